sdram_read_buffer: RTL and testbench

Buffers 32-bit words produced by the SDRAM read sequencer and hands them one at a time to the Wishbone slave front end of the SDRAM controller. It sits between the read sequencer's FIFO write port (fifo_wr/fifo_data/fifo_full) and the bus-side read logic. It applies early back-pressure so that words already in flight from the SDRAM (CAS latency plus pipeline) are never lost. It also tracks how many words of the current read burst remain to be delivered.

---
 rtl/sdram_read_buffer_pkg.sv | 12 +
 rtl/sdram_read_buffer_mem.sv | 40 ++++
 rtl/sdram_read_buffer.sv | 118 +++++++++++
 tb/tb_sdram_read_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_read_buffer_pkg.sv
// Shared SDRAM constants: data/count widths and burst tracker state encodings.
package sdram_read_buffer_pkg;

    localparam int SDRAM_FIFO_WIDTH  = 32;
    localparam int SDRAM_COUNT_WIDTH = 24;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } trk_state_e;

endpackage

// File: rtl/sdram_read_buffer_mem.sv
// Simple dual-port word store with a registered read port. The read register
// samples the old contents when reading and writing the same slot in one cycle.
module sdram_buffer_mem
    import sdram_read_buffer_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = SDRAM_FIFO_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Array write port; contents are never reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; holds the last delivered word between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_read_buffer.sv
// Read-data buffer between the SDRAM read sequencer and the bus-side read
// logic: early almost-full back-pressure, sticky overflow and a burst tracker.
module sdram_read_buffer
    import sdram_read_buffer_pkg::*;
#(
    parameter int DEPTH_LOG2  = 4,
    parameter int FULL_MARGIN = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fifo_wr,
    input  logic [SDRAM_FIFO_WIDTH-1:0]  fifo_data,
    output logic                         fifo_full,
    input  logic                         expect_load,
    input  logic [SDRAM_COUNT_WIDTH-1:0] expect_count,
    input  logic                         rd_stb,
    output logic [SDRAM_FIFO_WIDTH-1:0]  rd_data,
    output logic                         rd_ack,
    input  logic                         flush,
    output logic [DEPTH_LOG2:0]          level,
    output logic                         done,
    output logic                         overflow
);

    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [PW-1:0] DEPTH_LVL = PW'(DEPTH);
    localparam logic [PW-1:0] FULL_LVL  = PW'(DEPTH - FULL_MARGIN);
    localparam logic [SDRAM_COUNT_WIDTH-1:0] CNT_ONE = SDRAM_COUNT_WIDTH'(1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_cur, level_d;
    logic          empty, pop, push, drop;
    logic          fifo_full_q, rd_ack_q, overflow_q, overflow_d;

    trk_state_e                   state_q;
    logic [SDRAM_COUNT_WIDTH-1:0] remaining_q;
    logic                         done_q;

    // Next-state pointer/flag logic; flush overrides any concurrent write or read.
    always_comb begin
        level_cur  = wr_ptr_q - rd_ptr_q;
        empty      = (wr_ptr_q == rd_ptr_q);
        pop        = rd_stb && !empty && !flush;
        // A pop frees a slot in the same cycle, so a full buffer still accepts.
        push       = fifo_wr && !flush && ((level_cur < DEPTH_LVL) || pop);
        drop       = fifo_wr && !flush && !push;
        wr_ptr_d   = flush ? '0 : wr_ptr_q + {{(PW-1){1'b0}}, push};
        rd_ptr_d   = flush ? '0 : rd_ptr_q + {{(PW-1){1'b0}}, pop};
        level_d    = wr_ptr_d - rd_ptr_d;
        overflow_d = flush ? 1'b0 : (overflow_q | drop);
    end

    // Pointer and status registers; fifo_full uses the post-update level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_full_q <= 1'b0;
            rd_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_full_q <= (level_d >= FULL_LVL);
            rd_ack_q    <= pop;
            overflow_q  <= overflow_d;
        end
    end

    // Burst tracker: a reload wins over a same-cycle pop; remaining floors at 0.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            done_q      <= 1'b1;
        end else if (expect_load) begin
            remaining_q <= expect_count;
            if (expect_count != '0) begin
                state_q <= BUSY;
                done_q  <= 1'b0;
            end else begin
                state_q <= IDLE;
                done_q  <= 1'b1;
            end
        end else if (pop) begin
            if (remaining_q != '0) begin
                remaining_q <= remaining_q - CNT_ONE;
            end
            if (state_q == BUSY && remaining_q == CNT_ONE) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
            end
        end
    end

    sdram_buffer_mem #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (SDRAM_FIFO_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (push),
        .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wdata_i (fifo_data),
        .re_i    (pop),
        .raddr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rdata_o (rd_data)
    );

    assign fifo_full = fifo_full_q;
    assign rd_ack    = rd_ack_q;
    assign overflow  = overflow_q;
    assign level     = level_cur;
    assign done      = done_q;

endmodule

// File: tb/tb_sdram_read_buffer.sv
// Directed bench for sdram_read_buffer with a word scoreboard.
module tb_sdram_read_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_wr = 1'b0;
    logic [31:0] fifo_data = '0;
    logic        fifo_full;
    logic        expect_load = 1'b0;
    logic [23:0] expect_count = '0;
    logic        rd_stb = 1'b0;
    logic [31:0] rd_data;
    logic        rd_ack;
    logic        flush = 1'b0;
    logic [4:0]  level;
    logic        done;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    logic [31:0] sb_q[$];
    logic        m_ovf = 1'b0;

    sdram_read_buffer #(.DEPTH_LOG2(4), .FULL_MARGIN(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_wr      (fifo_wr),
        .fifo_data    (fifo_data),
        .fifo_full    (fifo_full),
        .expect_load  (expect_load),
        .expect_count (expect_count),
        .rd_stb       (rd_stb),
        .rd_data      (rd_data),
        .rd_ack       (rd_ack),
        .flush        (flush),
        .level        (level),
        .done         (done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: update the reference model from the driven inputs, advance,
    // then compare handshake, delivered word and occupancy flags.
    task automatic tick();
        logic        pop;
        logic        push;
        logic [31:0] w;
        w    = '0;
        pop  = rst_n && !flush && rd_stb && (sb_q.size() > 0);
        push = rst_n && !flush && fifo_wr && ((sb_q.size() < 16) || pop);
        if (!rst_n || flush) begin
            sb_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (pop) w = sb_q.pop_front();
            if (push) sb_q.push_back(fifo_data);
            else if (fifo_wr) m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("rd_ack", 32'(rd_ack), 32'(pop));
        if (pop) chk("rd_data", rd_data, w);
        chk("level", 32'(level), 32'(sb_q.size()));
        chk("fifo_full", 32'(fifo_full), 32'(sb_q.size() >= 12));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_done", 32'(done), 32'd1);
        chk("rst_rd_data", rd_data, 32'd0);
        rst_n = 1'b1;
        tick();

        // Three pushes, then three streamed reads
        for (int i = 1; i <= 3; i++) begin
            fifo_wr = 1'b1;
            fifo_data = 32'hA000_0000 + 32'(i);
            tick();
        end
        fifo_wr = 1'b0;
        chk("lvl3", 32'(level), 32'd3);
        tick();
        rd_stb = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rd_stb = 1'b0;
        chk("lvl0", 32'(level), 32'd0);
        tick();

        // Fill to threshold, to full, then one dropped word
        for (int i = 0; i < 12; i++) begin
            fifo_wr = 1'b1;
            fifo_data = 32'hB000_0000 + 32'(i);
            tick();
        end
        chk("full_at12", 32'(fifo_full), 32'd1);
        for (int i = 12; i < 16; i++) begin
            fifo_data = 32'hB000_0000 + 32'(i);
            tick();
        end
        chk("no_ovf16", 32'(overflow), 32'd0);
        fifo_data = 32'hBAD0_0017;
        tick();
        fifo_wr = 1'b0;
        chk("ovf17", 32'(overflow), 32'd1);
        chk("lvl16", 32'(level), 32'd16);

        // Flush clears overflow, refill, then push+pop across the wrap
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 16; i++) begin
            fifo_wr = 1'b1;
            fifo_data = 32'hC000_0000 + 32'(i);
            tick();
        end
        rd_stb = 1'b1;
        for (int i = 16; i < 26; i++) begin
            fifo_data = 32'hC000_0000 + 32'(i);
            tick();
            chk("pp_lvl", 32'(level), 32'd16);
        end
        fifo_wr = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        rd_stb = 1'b0;
        tick();

        // Burst of 5
        expect_load = 1'b1;
        expect_count = 24'd5;
        tick();
        expect_load = 1'b0;
        chk("done_load", 32'(done), 32'd0);
        for (int i = 0; i < 5; i++) begin
            fifo_wr = 1'b1;
            fifo_data = 32'hD000_0000 + 32'(i);
            tick();
        end
        fifo_wr = 1'b0;
        rd_stb = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("done_4th", 32'(done), 32'd0);
        tick();
        rd_stb = 1'b0;
        chk("done_5th", 32'(done), 32'd1);
        chk("ack_5th", 32'(rd_ack), 32'd1);
        expect_load = 1'b1;
        expect_count = 24'd0;
        tick();
        expect_load = 1'b0;
        chk("done_cnt0", 32'(done), 32'd1);

        // Flush mid-burst with a concurrent write
        expect_load = 1'b1;
        expect_count = 24'd3;
        tick();
        expect_load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            fifo_wr = 1'b1;
            fifo_data = 32'hE000_0000 + 32'(i);
            tick();
        end
        chk("lvl6", 32'(level), 32'd6);
        chk("done_busy", 32'(done), 32'd0);
        flush = 1'b1;
        fifo_data = 32'hDEAD_BEEF;
        tick();
        flush = 1'b0;
        chk("done_flush", 32'(done), 32'd1);
        fifo_data = 32'hE100_0001;
        tick();
        fifo_wr = 1'b0;
        rd_stb = 1'b1;
        tick();
        rd_stb = 1'b0;
        tick();

        // Reset while streaming
        expect_load = 1'b1;
        expect_count = 24'd8;
        tick();
        expect_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fifo_wr = 1'b1;
            fifo_data = 32'hF000_0000 + 32'(i);
            tick();
        end
        rd_stb = 1'b1;
        for (int i = 4; i < 6; i++) begin
            fifo_data = 32'hF000_0000 + 32'(i);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("rst_noedge_lvl", 32'(level), 32'd4);
        chk("rst_noedge_done", 32'(done), 32'd0);
        tick();
        chk("rst2_done", 32'(done), 32'd1);
        chk("rst2_rd_data", rd_data, 32'd0);
        rst_n = 1'b1;
        fifo_wr = 1'b0;
        rd_stb = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
